// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single data memory port.
// Each grant's requester ID is queued so every response returns to the requester that issued it.
module dmem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,

    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_err_i,

    output logic                    spurious_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic             fifo_id_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             lock_valid_r;
    logic             lock_id_r;
    logic             last_id_r;
    logic             spurious_r;

    logic             winner_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             mem_req_s;
    logic             handshake_s;
    logic             pop_s;
    logic             head_id_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return PTR_W'(0);
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Full is taken from the registered count, so a same-cycle pop never unblocks a request.
    assign fifo_full_s  = (count_r == CNT_MAX);
    assign fifo_empty_s = (count_r == CNT_W'(0));
    assign mem_req_s    = (m0_req_i | m1_req_i) & ~fifo_full_s;
    assign handshake_s  = mem_req_s & mem_gnt_i;
    assign pop_s        = mem_rvalid_i & ~fifo_empty_s;
    assign head_id_s    = fifo_id_r[rd_ptr_r];

    // Winner selection: a stalled request keeps its winner, otherwise round-robin.
    always_comb begin
        winner_s = 1'b0;
        if (lock_valid_r) begin
            winner_s = lock_id_r;
        end else if (m0_req_i && m1_req_i) begin
            winner_s = ~last_id_r;
        end else if (m1_req_i) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Memory request mux; the bus is held at zero when nothing is requested.
    always_comb begin
        mem_req_o   = mem_req_s;
        mem_addr_o  = {ADDR_WIDTH{1'b0}};
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_W{1'b0}};
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        if (mem_req_s) begin
            if (winner_s) begin
                mem_addr_o  = m1_addr_i;
                mem_we_o    = m1_we_i;
                mem_be_o    = m1_be_i;
                mem_wdata_o = m1_wdata_i;
            end else begin
                mem_addr_o  = m0_addr_i;
                mem_we_o    = m0_we_i;
                mem_be_o    = m0_be_i;
                mem_wdata_o = m0_wdata_i;
            end
        end else begin
            mem_addr_o  = {ADDR_WIDTH{1'b0}};
            mem_we_o    = 1'b0;
            mem_be_o    = {BE_W{1'b0}};
            mem_wdata_o = {DATA_WIDTH{1'b0}};
        end
    end

    assign m0_gnt_o    = handshake_s & ~winner_s;
    assign m1_gnt_o    = handshake_s &  winner_s;
    assign m0_rvalid_o = pop_s & ~head_id_s;
    assign m1_rvalid_o = pop_s &  head_id_s;
    assign m0_err_o    = m0_rvalid_o & mem_err_i;
    assign m1_err_o    = m1_rvalid_o & mem_err_i;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign spurious_o  = spurious_r;

    // ID FIFO, lock, round-robin history and spurious-response flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_id_r[i] <= 1'b0;
            end
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            lock_valid_r <= 1'b0;
            lock_id_r    <= 1'b0;
            last_id_r    <= 1'b1;
            spurious_r   <= 1'b0;
        end else begin
            if (handshake_s) begin
                fifo_id_r[wr_ptr_r] <= winner_s;
                wr_ptr_r            <= next_ptr(wr_ptr_r);
                last_id_r           <= winner_s;
                lock_valid_r        <= 1'b0;
            end else if (mem_req_s) begin
                lock_valid_r <= 1'b1;
                lock_id_r    <= winner_s;
            end else begin
                lock_valid_r <= lock_valid_r;
            end

            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({handshake_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase

            if (mem_rvalid_i && fifo_empty_s) begin
                spurious_r <= 1'b1;
            end else begin
                spurious_r <= spurious_r;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: reset, routing, round-robin, lock, full FIFO, spurious.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m0_gnt_o, m0_rvalid_o, m0_we_i, m0_err_o;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic [3:0]  m0_be_i;
    logic        m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i, m1_err_o;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [3:0]  m1_be_i;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        spurious_o;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic r0, input logic r1, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic er);
        @(negedge clk_i);
        m0_req_i = r0; m1_req_i = r1; mem_gnt_i = gnt;
        mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        m0_req_i = 1'b0; m1_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m0_req_i = 1'b0; m1_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, mem_req_o, spurious_o} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000000",
                {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, mem_req_o, spurious_o});
        end
        total++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== 69'h0) begin
            bad++; $display("FAIL reset_bus got=%h want=0", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o});
        end
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++;
        if ({m0_gnt_o, m1_gnt_o, mem_req_o, mem_addr_o, spurious_o} !== 35'h0) begin
            bad++; $display("FAIL post_reset got=%h want=0", {m0_gnt_o, m1_gnt_o, mem_req_o, mem_addr_o, spurious_o});
        end
    endtask

    task automatic test_single_read();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({m0_gnt_o, m1_gnt_o, mem_req_o} !== 3'b101 || mem_addr_o !== 32'h10) begin
            bad++; $display("FAIL single_gnt got gnt0/gnt1/req=%b addr=%h want 101 addr=10",
                {m0_gnt_o, m1_gnt_o, mem_req_o}, mem_addr_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        total++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_err_o} !== 3'b100 || m0_rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_rvalid got rv0/rv1/err=%b rdata=%h want 100 rdata=deadbeef",
                {m0_rvalid_o, m1_rvalid_o, m0_err_o}, m0_rdata_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++;
        if ({m0_rvalid_o, m1_rvalid_o, spurious_o} !== 3'b000) begin
            bad++; $display("FAIL single_idle got=%b want=000", {m0_rvalid_o, m1_rvalid_o, spurious_o});
        end
    endtask

    task automatic test_contention();
        logic       exp_g;
        logic       exp_r;
        logic [1:0] exp_err;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(c < 4, c < 4, c < 4, c >= 1, 32'hA0000000 + 32'(c), c == 3);
            exp_g = (c % 2) == 1;
            exp_r = ((c - 1) % 2) == 1;
            total++;
            if (c < 4 && {m1_gnt_o, m0_gnt_o} !== (exp_g ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_gnt c=%0d got {g1,g0}=%b want winner m%0d", c, {m1_gnt_o, m0_gnt_o}, exp_g);
            end else if (c == 4 && {m1_gnt_o, m0_gnt_o} !== 2'b00) begin
                bad++; $display("FAIL rr_gnt c=4 got {g1,g0}=%b want 00", {m1_gnt_o, m0_gnt_o});
            end
            if (c < 4 && exp_g) begin
                total++;
                if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {32'h20, 1'b1, 4'h3, 32'h12345678}) begin
                    bad++; $display("FAIL rr_wbus c=%0d got addr=%h we=%b be=%h wd=%h want 20 1 3 12345678",
                        c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
                end
            end
            if (c >= 1) begin
                exp_err = (c == 3) ? (exp_r ? 2'b10 : 2'b01) : 2'b00;
                total++;
                if ({m1_rvalid_o, m0_rvalid_o} !== (exp_r ? 2'b10 : 2'b01) || {m1_err_o, m0_err_o} !== exp_err
                    || (exp_r ? m1_rdata_o : m0_rdata_o) !== 32'hA0000000 + 32'(c)) begin
                    bad++; $display("FAIL rr_rvalid c=%0d got {rv1,rv0}=%b {e1,e0}=%b want m%0d err=%b",
                        c, {m1_rvalid_o, m0_rvalid_o}, {m1_err_o, m0_err_o}, exp_r, exp_err);
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, c > 0, 1'b0, 1'b0, 32'h0, 1'b0);
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || {m0_gnt_o, m1_gnt_o} !== 2'b00) begin
                bad++; $display("FAIL lock_hold c=%0d got req=%b addr=%h gnts=%b want 1 10 00",
                    c, mem_req_o, mem_addr_o, {m0_gnt_o, m1_gnt_o});
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            bad++; $display("FAIL lock_release got {g0,g1}=%b want 10", {m0_gnt_o, m1_gnt_o});
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0);
        total++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0110) begin
            bad++; $display("FAIL lock_next got g0g1rv0rv1=%b want 0110", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        total++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin
            bad++; $display("FAIL lock_drain got rv0rv1=%b want 01", {m0_rvalid_o, m1_rvalid_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_full();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
            bad++; $display("FAIL full_second got {g0,g1}=%b want 01", {m0_gnt_o, m1_gnt_o});
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o} !== 3'b000 || mem_addr_o !== 32'h0) begin
            bad++; $display("FAIL full_block got req/g0/g1=%b addr=%h want 000 0", {mem_req_o, m0_gnt_o, m1_gnt_o}, mem_addr_o);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0);
        total++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 5'b00010) begin
            bad++; $display("FAIL full_pop_block got req/g0/g1/rv0/rv1=%b want 00010",
                {mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o});
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o} !== 3'b110) begin
            bad++; $display("FAIL full_resume got req/g0/g1=%b want 110", {mem_req_o, m0_gnt_o, m1_gnt_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
        total++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin
            bad++; $display("FAIL full_order1 got rv0rv1=%b want 01", {m0_rvalid_o, m1_rvalid_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        total++;
        if ({m0_rvalid_o, m1_rvalid_o, spurious_o} !== 3'b100) begin
            bad++; $display("FAIL full_order2 got rv0rv1sp=%b want 100", {m0_rvalid_o, m1_rvalid_o, spurious_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_spurious();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 1'b1);
        total++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, spurious_o} !== 5'b00000) begin
            bad++; $display("FAIL spur_drop got=%b want=00000", {m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, spurious_o});
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            total++;
            if (spurious_o !== 1'b1) begin
                bad++; $display("FAIL spur_sticky c=%0d got=%b want=1", c, spurious_o);
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        total++;
        if (spurious_o !== 1'b0) begin
            bad++; $display("FAIL spur_clear got=%b want=0", spurious_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
            bad++; $display("FAIL mid_gnt got {g0,g1}=%b want 01", {m0_gnt_o, m1_gnt_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst_ni = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
        rst_ni = 1'b1;
        total++;
        if ({m0_rvalid_o, m1_rvalid_o, spurious_o} !== 3'b000) begin
            bad++; $display("FAIL mid_drop got rv0rv1sp=%b want 000", {m0_rvalid_o, m1_rvalid_o, spurious_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++;
        if (spurious_o !== 1'b1) begin
            bad++; $display("FAIL mid_spur got=%b want=1", spurious_o);
        end
    endtask

    initial begin
        m0_addr_i = 32'h10; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h0;
        m1_addr_i = 32'h20; m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'h12345678;
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_full();
        test_spurious();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
